// File: rtl/bcd_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : bcd_pkg                                                         |
// | Purpose  : Shared types and constants for the sequential BCD converter.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bcd_state_t;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// +----------------------------------------------------------------------------+
// | Module   : bcd_digit_adj                                                   |
// | Purpose  : Double-dabble correction cell: add 3 to a digit of 5 or more.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module bcd_digit_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t raw,
  output bcd_digit_t adj
);

  // Input digit never exceeds 9, so the sum always fits in 4 bits.
  assign adj = (raw >= ADD3_THRESH) ? bcd_digit_t'(raw + 4'd3) : raw;

endmodule

`default_nettype wire

// File: rtl/bcd_converter_seq.sv
// +----------------------------------------------------------------------------+
// | Module   : bcd_converter_seq                                               |
// | Purpose  : Iterative binary-to-BCD converter, one input bit per clock.     |
// |            Define BCD_BLANK_EN to add the leading-zero blank output.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module bcd_converter_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 11,
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          ready,
  output logic                          busy,
  output logic                          valid,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          overflow
`ifdef BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]             blank
`endif
);

  localparam int C_CNT_W = $clog2(WIDTH + 1);
  localparam int C_BCD_W = BCD_DIGIT_W * DIGITS;

  bcd_state_t         r_state;
  bcd_state_t         w_next_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [C_BCD_W-1:0] r_acc;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_ovf;
  logic               r_valid;
  logic [C_BCD_W-1:0] r_bcd;
  logic               r_overflow;
  logic [C_BCD_W-1:0] w_corr;
  logic [C_BCD_W-1:0] w_acc_next;
  logic               w_carry_out;
  logic               w_last;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_adj u_adj (
        .raw (r_acc[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .adj (w_corr[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Corrected accumulator shifted left, pulling in the next operand bit.
  assign w_acc_next  = {w_corr[C_BCD_W-2:0], r_shreg[WIDTH-1]};
  assign w_carry_out = w_corr[C_BCD_W-1];
  assign w_last      = (r_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start)  w_next_state = SHIFT;
      SHIFT:   if (w_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == IDLE);
    busy  = (r_state != IDLE);
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] w_blank;
  logic [DIGITS-1:0] r_blank;

  // A digit blanks only when it and every digit above it are zero; digit 0 always shows.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_units
        assign w_blank[gi] = 1'b0;
      end else if (gi == DIGITS - 1) begin : g_top
        assign w_blank[gi] = (w_acc_next[gi*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      end else begin : g_mid
        assign w_blank[gi] = (w_acc_next[gi*BCD_DIGIT_W +: BCD_DIGIT_W] == '0) & w_blank[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blank <= '1;
    end else if (r_state == SHIFT && w_last) begin
      r_blank <= w_blank;
    end
  end

  assign blank = r_blank;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg    <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shreg <= bin;
            r_acc   <= '0;
            r_cnt   <= C_CNT_W'(WIDTH - 1);
            r_ovf   <= 1'b0;
          end
        end
        SHIFT: begin
          r_acc   <= w_acc_next;
          r_shreg <= r_shreg << 1;
          r_cnt   <= r_cnt - C_CNT_W'(1);
          r_ovf   <= r_ovf | w_carry_out;
          if (w_last) begin
            r_bcd      <= w_acc_next;
            r_overflow <= r_ovf | w_carry_out;
            r_valid    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid    = r_valid;
  assign bcd      = r_bcd;
  assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_bcd_converter_seq.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_bcd_converter_seq                                            |
// | Purpose  : Directed self-checking bench for bcd_converter_seq.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bcd_converter_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1, start2;
  logic [10:0] bin;
  logic        ready0, ready1, ready2;
  logic        busy0, busy1, busy2;
  logic        valid0, valid1, valid2;
  logic [15:0] bcd0;
  logic [11:0] bcd1, bcd2;
  logic        ovf0, ovf1, ovf2;
`ifdef BCD_BLANK_EN
  logic [3:0]  blank0;
  logic [2:0]  blank1, blank2;
`endif

  int   vectors     = 0;
  int   miscompares = 0;
  int   cur         = 0;
  logic sel_valid;

  always #5 clk = ~clk;

  bcd_converter_seq #(.WIDTH(11), .DIGITS(4)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .bin(bin),
    .ready(ready0), .busy(busy0), .valid(valid0), .bcd(bcd0), .overflow(ovf0)
`ifdef BCD_BLANK_EN
    , .blank(blank0)
`endif
  );

  bcd_converter_seq #(.WIDTH(11), .DIGITS(3)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .bin(bin),
    .ready(ready1), .busy(busy1), .valid(valid1), .bcd(bcd1), .overflow(ovf1)
`ifdef BCD_BLANK_EN
    , .blank(blank1)
`endif
  );

  bcd_converter_seq #(.WIDTH(8), .DIGITS(3)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .bin(bin[7:0]),
    .ready(ready2), .busy(busy2), .valid(valid2), .bcd(bcd2), .overflow(ovf2)
`ifdef BCD_BLANK_EN
    , .blank(blank2)
`endif
  );

  always_comb begin
    sel_valid = valid0;
    case (cur)
      1:       sel_valid = valid1;
      2:       sel_valid = valid2;
      default: sel_valid = valid0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on one instance and count edges until its valid rises.
  task automatic run(input int sel, input logic [10:0] v,
                     output int lat, output logic [15:0] r, output logic o);
    cur = sel;
    @(negedge clk);
    bin = v;
    case (sel)
      0:       start0 = 1'b1;
      1:       start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    lat = 0;
    while (!sel_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    case (sel)
      0:       begin r = bcd0;          o = ovf0; end
      1:       begin r = {4'h0, bcd1};  o = ovf1; end
      default: begin r = {4'h0, bcd2};  o = ovf2; end
    endcase
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [15:0] r;
    logic        o;
    logic [11:0] e;

    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; bin = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_busy",  {31'd0, busy0},  32'd0);
    chk("rst_valid", {31'd0, valid0}, 32'd0);
    chk("rst_bcd",   {16'd0, bcd0},   32'd0);
    chk("rst_ovf",   {31'd0, ovf0},   32'd0);
    chk("rst_sub",   {26'd0, ready1, ready2, busy1, busy2, valid1, valid2}, 32'b110000);
`ifdef BCD_BLANK_EN
    chk("rst_blank", {22'd0, blank0, blank1, blank2}, 32'h3ff);
`endif
    reset = 1'b0;

    run(0, 11'd2047, lat, r, o);
    chk("max_lat", lat, 11);
    chk("max_bcd", {16'd0, r}, 32'h2047);
    chk("max_ovf", {31'd0, o}, 32'd0);
    @(posedge clk); #1;
    chk("valid_pulse", {31'd0, valid0}, 32'd0);

    run(0, 11'd0, lat, r, o);
    chk("zero_bcd", {16'd0, r}, 32'h0000);
    chk("zero_ovf", {31'd0, o}, 32'd0);
`ifdef BCD_BLANK_EN
    chk("zero_blank", {28'd0, blank0}, 32'b1110);
`endif
    run(0, 11'd5, lat, r, o);
    chk("five_bcd", {16'd0, r}, 32'h0005);
`ifdef BCD_BLANK_EN
    chk("five_blank", {28'd0, blank0}, 32'b1110);
`endif
    run(0, 11'd1030, lat, r, o);
    chk("k1030_bcd", {16'd0, r}, 32'h1030);
`ifdef BCD_BLANK_EN
    chk("k1030_blank", {28'd0, blank0}, 32'b0000);
`endif

    // Back-to-back: a start while busy is dropped, a start on the valid cycle is taken.
    cur = 0;
    @(negedge clk); bin = 11'd999; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    chk("b2b_busy", {31'd0, busy0}, 32'd1);
    repeat (3) @(posedge clk);
    #1; bin = 11'd123; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    lat = 4;
    while (!valid0 && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("b2b_lat", lat, 11);
    chk("b2b_bcd", {16'd0, bcd0}, 32'h0999);
    bin = 11'd42; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    chk("b2b_single", {31'd0, valid0}, 32'd0);
    chk("b2b_accept", {31'd0, busy0}, 32'd1);
    lat = 0;
    while (!valid0 && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("b2b42_lat", lat, 11);
    chk("b2b42_bcd", {16'd0, bcd0}, 32'h0042);
`ifdef BCD_BLANK_EN
    chk("b2b42_blank", {28'd0, blank0}, 32'b1100);
`endif

    // Asynchronous abort mid-conversion.
    @(negedge clk); bin = 11'd1234; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (4) @(posedge clk);
    #2; reset = 1'b1;
    #1;
    chk("abort_ready", {31'd0, ready0}, 32'd1);
    chk("abort_busy",  {31'd0, busy0},  32'd0);
    chk("abort_bcd",   {16'd0, bcd0},   32'd0);
    chk("abort_ovf",   {31'd0, ovf0},   32'd0);
`ifdef BCD_BLANK_EN
    chk("abort_blank", {28'd0, blank0}, 32'hf);
`endif
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (valid0) seen = 1; end
    chk("abort_novalid", seen, 0);
    run(0, 11'd1234, lat, r, o);
    chk("k1234_lat", lat, 11);
    chk("k1234_bcd", {16'd0, r}, 32'h1234);

    run(1, 11'd2047, lat, r, o);
    chk("d3_max_lat", lat, 11);
    chk("d3_max_bcd", {16'd0, r}, 32'h0047);
    chk("d3_max_ovf", {31'd0, o}, 32'd1);
    run(1, 11'd999, lat, r, o);
    chk("d3_999_bcd", {16'd0, r}, 32'h0999);
    chk("d3_999_ovf", {31'd0, o}, 32'd0);

    for (int v = 0; v < 256; v++) begin
      run(2, 11'(v), lat, r, o);
      e = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      chk($sformatf("sweep_bcd_%0d", v), {16'd0, r}, {20'd0, e});
      chk($sformatf("sweep_ovf_%0d", v), {31'd0, o}, 32'd0);
      chk($sformatf("sweep_lat_%0d", v), lat, 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_converter_seq.md
Name: bcd_converter_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using the iterative shift-and-add-3 (double-dabble) algorithm.
- Processes one input bit per clock, so a single bank of DIGITS digit-correction cells replaces a full combinational add-3 array.
- Start/valid handshake. Sits between binary datapaths (counters, ALU results) and seven-segment/display drivers.

Parameters:
- WIDTH, 11, bit width of the binary input.
- DIGITS, 4, number of 4-bit BCD output digits. Overflow is flagged if too few digits are configured (see Behaviour).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only when ready=1.
- bin  input  WIDTH  binary operand; captured on the accepted start edge.
- ready  output  1  high in IDLE; conversion may be accepted.
- busy  output  1  high while in SHIFT; equals ~ready.
- valid  output  1  one-cycle pulse when bcd/overflow are updated.
- bcd  output  4*DIGITS  result, digit 0 in [3:0]; held until the next completion.
- overflow  output  1  result exceeded DIGITS digits; held with bcd.

Behaviour:
- Reset (async, any state): state=IDLE, bcd=0, overflow=0, valid=0, shift/accumulator/counter registers=0, ready=1, busy=0.
- FSM states: IDLE, SHIFT.
- IDLE: on a rising edge with start=1:
  - shift register <= bin; accumulator <= 0; bit counter <= WIDTH-1; state <= SHIFT.
  - start=0 keeps IDLE.
- SHIFT, each edge:
  - Every accumulator digit >=5 gets +3 (4-bit wrap never occurs because the input digit is <=9).
  - Then {acc, shreg} is shifted left 1.
  - If the bit shifted out of the top digit is 1, the internal ovf flag is set.
  - Counter decrements.
- Final SHIFT edge (counter=0):
  - bcd <= corrected/shifted accumulator; overflow <= ovf; valid <= 1; state <= IDLE.
- Latency: start accepted at edge k; valid is high in the cycle following edge k+WIDTH. Throughput is one conversion per WIDTH+1 cycles.
- valid is 1 for exactly one cycle and 0 otherwise.
- start while busy=1 is ignored; no queueing. Changes to bin after acceptance have no effect.
- start in the same cycle valid=1 is accepted (state is already IDLE).
- Reset mid-conversion aborts it. No valid is produced, and bcd/overflow clear to 0.
- WIDTH=1: legal; conversion takes 1 SHIFT cycle.

Optional Feature:
- Macro: BCD_BLANK_EN.
- Defined:
  - Extra output blank [DIGITS-1:0], registered alongside bcd and reset to all-ones.
  - blank[i]=1 when digit i and all digits above it are zero.
  - blank[0] is forced 0, so a value of 0 shows a single "0".
- Undefined: the port is absent and no logic is added.

Decomposition:
- Package bcd_pkg:
  - localparam BCD_DIGIT_W=4 and ADD3_THRESH=4'd5.
  - typedef enum logic {IDLE, SHIFT} bcd_state_t.
  - typedef logic [3:0] bcd_digit_t.
- Sub-module bcd_digit_adj: combinational, in bcd_digit_t, out bcd_digit_t = (in>=5) ? in+3 : in. Instantiated DIGITS times via generate.
- Counter width: $clog2(WIDTH+1).

Test Plan:
- WIDTH=11, DIGITS=4, bin=2047, start pulse -> valid exactly 11 cycles after start edge, bcd=16'h2047, overflow=0.
- bin=0 -> bcd=16'h0000, overflow=0; with BCD_BLANK_EN, blank=4'b1110. bin=5 -> bcd=16'h0005, blank=4'b1110. bin=1030 -> blank=4'b0000.
- Back-to-back: start(bin=999) accepted; start(bin=123) pulsed while busy is ignored -> single valid, bcd=16'h0999. Then start on the valid cycle (bin=42) -> next valid gives bcd=16'h0042.
- Reset asserted 5 cycles into converting bin=1234 -> ready=1, bcd=0 immediately (async), no valid. A new start(bin=1234) then yields 16'h1234.
- WIDTH=11, DIGITS=3, bin=2047 -> overflow=1, bcd=12'h047. bin=999 -> overflow=0, bcd=12'h999.
- Exhaustive sweep for WIDTH=8, DIGITS=3: all 256 values match the reference model, each with latency 8.
